// File: rtl/hsst_tx_framer.sv
// HSST TX framer: drains fixed-length bursts from the TX FIFO and wraps each one as
// SOF / header / payload / checksum / EOF, with IDLE commas between frames.
module hsst_tx_framer #(
    parameter int FRAME_LEN   = 256,
    parameter int IDLE_GAP    = 2,
    parameter int LEVEL_WIDTH = 11
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst_n,
    input  logic                   link_up,
    input  logic [31:0]            fifo_rd_data,
    input  logic                   fifo_empty,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
    output logic                   fifo_rd_en,
    output logic [31:0]            tx_data,
    output logic [3:0]             tx_kchar,
    output logic                   busy,
    output logic [15:0]            frame_cnt,
    output logic                   err_underflow
);

    localparam logic [31:0] IDLE_WORD   = 32'h5050_50BC;
    localparam logic [31:0] SOF_WORD    = 32'h5A5A_5AFB;
    localparam logic [31:0] FRAME_LEN_U = 32'(FRAME_LEN);
    localparam logic [15:0] FRAME_LEN_H = 16'(FRAME_LEN);
    localparam logic [9:0]  FRAME_LEN_W = 10'(FRAME_LEN);
    localparam logic [9:0]  LAST_WORD   = 10'(FRAME_LEN - 1);
    localparam logic [3:0]  GAP_LEN     = 4'(IDLE_GAP);

    typedef enum logic [2:0] {
        S_IDLE, S_SOF, S_HDR, S_PAY, S_CHK, S_EOF, S_GAP
    } state_t;

    state_t      state, state_nxt;
    logic [9:0]  word_cnt, word_cnt_nxt;
    logic [9:0]  rd_cnt, rd_cnt_nxt;
    logic [3:0]  gap_cnt, gap_cnt_nxt;
    logic [7:0]  seq, seq_nxt;
    logic [31:0] sum, sum_nxt;
    logic [31:0] tx_data_nxt;
    logic [3:0]  tx_kchar_nxt;
    logic        rd_en_nxt, busy_nxt, err_nxt;
    logic [15:0] frame_cnt_nxt;
    logic        start_ok, launch;

    // The level is only trusted between frames; a frame is never started half-buffered.
    assign start_ok = link_up && (32'(fifo_rd_water_level) >= FRAME_LEN_U);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) state <= S_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        tx_data_nxt   = IDLE_WORD;
        tx_kchar_nxt  = 4'b0001;
        rd_en_nxt     = 1'b0;
        busy_nxt      = 1'b0;
        word_cnt_nxt  = word_cnt;
        rd_cnt_nxt    = rd_cnt;
        gap_cnt_nxt   = gap_cnt;
        seq_nxt       = seq;
        sum_nxt       = sum;
        frame_cnt_nxt = frame_cnt;
        err_nxt       = err_underflow | (fifo_rd_en & fifo_empty);
        launch        = 1'b0;

        // Reads run independently of the output state: FRAME_LEN strobes from SOF on.
        if (fifo_rd_en) begin
            rd_cnt_nxt = rd_cnt + 10'd1;
            rd_en_nxt  = (rd_cnt + 10'd1) < FRAME_LEN_W;
        end

        case (state)
            S_IDLE: launch = start_ok;
            S_SOF: begin
                state_nxt    = S_HDR;
                tx_data_nxt  = {8'hA5, seq, FRAME_LEN_H};
                tx_kchar_nxt = 4'b0000;
                busy_nxt     = 1'b1;
            end
            S_HDR: begin
                state_nxt    = S_PAY;
                tx_data_nxt  = fifo_rd_data;
                tx_kchar_nxt = 4'b0000;
                busy_nxt     = 1'b1;
                sum_nxt      = sum + fifo_rd_data;
                word_cnt_nxt = 10'd0;
            end
            S_PAY: begin
                tx_kchar_nxt = 4'b0000;
                busy_nxt     = 1'b1;
                if (word_cnt == LAST_WORD) begin
                    state_nxt   = S_CHK;
                    tx_data_nxt = sum;
                end else begin
                    tx_data_nxt  = fifo_rd_data;
                    sum_nxt      = sum + fifo_rd_data;
                    word_cnt_nxt = word_cnt + 10'd1;
                end
            end
            S_CHK: begin
                state_nxt     = S_EOF;
                tx_data_nxt   = {8'h00, seq, 8'h00, 8'hFD};
                busy_nxt      = 1'b1;
                seq_nxt       = seq + 8'd1;
                frame_cnt_nxt = frame_cnt + 16'd1;
            end
            S_EOF: begin
                state_nxt   = S_GAP;
                gap_cnt_nxt = 4'd1;
            end
            S_GAP: begin
                // The last gap word doubles as the first IDLE evaluation cycle.
                if (gap_cnt >= GAP_LEN) begin
                    launch    = start_ok;
                    state_nxt = S_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + 4'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (launch) begin
            state_nxt    = S_SOF;
            tx_data_nxt  = SOF_WORD;
            tx_kchar_nxt = 4'b0001;
            rd_en_nxt    = 1'b1;
            rd_cnt_nxt   = 10'd0;
            busy_nxt     = 1'b1;
            sum_nxt      = 32'd0;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            tx_data       <= IDLE_WORD;
            tx_kchar      <= 4'b0001;
            fifo_rd_en    <= 1'b0;
            busy          <= 1'b0;
            frame_cnt     <= 16'd0;
            err_underflow <= 1'b0;
            seq           <= 8'd0;
            sum           <= 32'd0;
            gap_cnt       <= 4'd0;
            word_cnt      <= 10'd0;
            rd_cnt        <= 10'd0;
        end else begin
            tx_data       <= tx_data_nxt;
            tx_kchar      <= tx_kchar_nxt;
            fifo_rd_en    <= rd_en_nxt;
            busy          <= busy_nxt;
            frame_cnt     <= frame_cnt_nxt;
            err_underflow <= err_nxt;
            seq           <= seq_nxt;
            sum           <= sum_nxt;
            gap_cnt       <= gap_cnt_nxt;
            word_cnt      <= word_cnt_nxt;
            rd_cnt        <= rd_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_hsst_tx_framer.sv
// Scoreboard bench for hsst_tx_framer: a FIFO model feeds the DUT, a frame builder queues
// the expected line words, and a monitor checks every non-idle word plus busy/rd_en timing.
module tb_hsst_tx_framer;

    localparam int FL  = 4;
    localparam int GAP = 2;
    localparam int LW  = 11;
    localparam logic [31:0] IDLE_W = 32'h5050_50BC;
    localparam logic [31:0] SOF_W  = 32'h5A5A_5AFB;

    logic          rd_clk, rd_rst_n, link_up, force_empty;
    logic [31:0]   fifo_rd_data;
    logic          fifo_empty, fifo_empty_r;
    logic [LW-1:0] fifo_level;
    logic          fifo_rd_en, busy, err_underflow;
    logic [31:0]   tx_data;
    logic [3:0]    tx_kchar;
    logic [15:0]   frame_cnt;

    hsst_tx_framer #(.FRAME_LEN(FL), .IDLE_GAP(GAP), .LEVEL_WIDTH(LW)) dut (
        .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .link_up(link_up),
        .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .fifo_rd_water_level(fifo_level), .fifo_rd_en(fifo_rd_en),
        .tx_data(tx_data), .tx_kchar(tx_kchar), .busy(busy),
        .frame_cnt(frame_cnt), .err_underflow(err_underflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    // FIFO model: queued words, registered level/empty, read data one cycle after rd_en
    logic [31:0] fifo_q[$];
    logic [31:0] push_q[$];
    initial begin
        fifo_level   = '0;
        fifo_empty_r = 1'b1;
        fifo_rd_data = '0;
    end
    assign fifo_empty = fifo_empty_r | force_empty;

    always @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            fifo_q.delete();
            fifo_level   <= '0;
            fifo_empty_r <= 1'b1;
        end else begin
            if (fifo_rd_en) begin
                if (fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
                else                   fifo_rd_data <= 32'hBAD0_0000;
            end
            while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
            fifo_level   <= LW'(fifo_q.size());
            fifo_empty_r <= (fifo_q.size() == 0);
        end
    end

    // Reference model: every FL words written form one frame on the line.
    logic [35:0] exp_q[$];
    logic [31:0] pend_q[$];
    logic [7:0]  model_seq = 8'd0;

    task automatic push_word(input logic [31:0] w);
        logic [31:0] s;
        push_q.push_back(w);
        pend_q.push_back(w);
        if (pend_q.size() == FL) begin
            s = 32'd0;
            exp_q.push_back({SOF_W, 4'b0001});
            exp_q.push_back({8'hA5, model_seq, 16'(FL), 4'b0000});
            foreach (pend_q[i]) begin
                exp_q.push_back({pend_q[i], 4'b0000});
                s = s + pend_q[i];
            end
            exp_q.push_back({s, 4'b0000});
            exp_q.push_back({8'h00, model_seq, 8'h00, 8'hFD, 4'b0001});
            model_seq = model_seq + 8'd1;
            pend_q.delete();
        end
    endtask

    // Monitor
    int          pos = 0, eof_seen = 0, idle_run = 100;
    bit          in_frame = 0, b2b = 0, is_idle;
    logic [35:0] e;

    always @(negedge rd_clk) begin
        if (!rd_rst_n) begin
            pos = 0; in_frame = 0; eof_seen = 0; idle_run = 100; b2b = 0;
        end else begin
            is_idle = (tx_data == IDLE_W) && (tx_kchar == 4'b0001);
            check("busy", 64'(busy), 64'(!is_idle));
            if (!is_idle) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {28'd0, tx_data, tx_kchar}, {28'd0, IDLE_W, 4'b0001});
                end else begin
                    e = exp_q.pop_front();
                    check("tx_word", {28'd0, tx_data, tx_kchar}, {28'd0, e});
                end
                if (!in_frame) begin
                    in_frame = 1; pos = 0;
                    if (eof_seen > 0) check("gap_min", 64'(idle_run >= GAP), 64'd1);
                    if (b2b) check("gap_exact", 64'(idle_run), 64'(GAP));
                end
                check("rd_en_frame", 64'(fifo_rd_en), 64'(pos < FL));
                if (pos == FL + 3) begin
                    in_frame = 0;
                    eof_seen++;
                    check("frame_cnt", 64'(frame_cnt), 64'(16'(eof_seen)));
                    b2b = link_up && (exp_q.size() > 0);
                    idle_run = 0;
                end
                pos++;
            end else begin
                check("rd_en_idle", 64'(fifo_rd_en), 64'd0);
                idle_run++;
            end
        end
    end

    task automatic wait_sof(input int lim);
        bit got = 0;
        for (int i = 0; i < lim && !got; i++) begin
            @(negedge rd_clk);
            got = (tx_data == SOF_W) && (tx_kchar == 4'b0001);
        end
        check("sof_seen", 64'(got), 64'd1);
    endtask

    task automatic wait_drain(input int lim);
        for (int i = 0; i < lim && exp_q.size() > 0; i++) @(negedge rd_clk);
        @(negedge rd_clk);
        check("drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_idle_cycles(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge rd_clk);
            check(name, {28'd0, tx_data, tx_kchar}, {28'd0, IDLE_W, 4'b0001});
        end
    endtask

    int fc;

    initial begin
        rd_rst_n = 1'b0; link_up = 1'b0; force_empty = 1'b0;

        // Reset held with random control inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge rd_clk); #1;
            link_up     = 1'($urandom);
            force_empty = 1'($urandom);
            #1;
            check("rst_tx", {28'd0, tx_data, tx_kchar}, {28'd0, IDLE_W, 4'b0001});
            check("rst_ctl", 64'({fifo_rd_en, busy, err_underflow}), 64'd0);
            check("rst_fcnt", 64'(frame_cnt), 64'd0);
        end
        force_empty = 1'b0; link_up = 1'b1;
        @(negedge rd_clk); #1 rd_rst_n = 1'b1;

        // Below-threshold level keeps the line idle
        push_word(32'd1); push_word(32'd2); push_word(32'd3);
        check_idle_cycles("idle_low_level", 10);

        // Single frame 1,2,3,4
        #1 push_word(32'd4);
        wait_drain(40);
        check("fcnt_single", 64'(frame_cnt), 64'd1);

        // Checksum wrap
        #1 for (int i = 0; i < FL; i++) push_word(32'hFFFF_FFFF);
        wait_drain(40);
        check("fcnt_wrap", 64'(frame_cnt), 64'd2);

        // 256 back-to-back frames (seq wraps through 255 -> 0)
        #1 for (int i = 0; i < 256 * FL; i++) push_word($urandom);
        wait_drain(4000);
        check("fcnt_b2b", 64'(frame_cnt), 64'd258);

        // link_up low: idle despite a deep FIFO
        #1 link_up = 1'b0;
        for (int i = 0; i < 100; i++) push_word($urandom);
        check_idle_cycles("idle_link_down", 20);
        #1 link_up = 1'b1;
        @(negedge rd_clk);
        check("sof_after_link", {28'd0, tx_data, tx_kchar}, {28'd0, SOF_W, 4'b0001});
        wait_sof(30);
        for (int i = 0; i < 3; i++) @(negedge rd_clk);
        #1 link_up = 1'b0;
        fc = int'(frame_cnt);
        for (int i = 0; i < 10; i++) @(negedge rd_clk);
        check("frame_done_after_drop", 64'(frame_cnt), 64'(fc + 1));
        check_idle_cycles("idle_after_drop", 15);

        // Underflow during a payload read
        check("no_underflow_yet", 64'(err_underflow), 64'd0);
        #1 link_up = 1'b1;
        wait_sof(30);
        #1 force_empty = 1'b1;
        @(negedge rd_clk); #1 force_empty = 1'b0;
        @(negedge rd_clk);
        check("underflow_set", 64'(err_underflow), 64'd1);
        for (int i = 0; i < 20; i++) @(negedge rd_clk);
        check("underflow_sticky", 64'(err_underflow), 64'd1);

        // Reset at payload word 2 abandons the frame
        wait_sof(30);
        for (int i = 0; i < 4; i++) @(negedge rd_clk);
        #2 rd_rst_n = 1'b0;
        #1;
        check("midrst_tx", {28'd0, tx_data, tx_kchar}, {28'd0, IDLE_W, 4'b0001});
        check("midrst_ctl", 64'({fifo_rd_en, busy, err_underflow}), 64'd0);
        exp_q.delete(); pend_q.delete(); push_q.delete();
        model_seq = 8'd0;
        @(negedge rd_clk); @(negedge rd_clk); #1 rd_rst_n = 1'b1;
        for (int i = 0; i < FL; i++) push_word($urandom);
        wait_sof(30);
        @(negedge rd_clk);
        check("hdr_seq0", 64'(tx_data), 64'(32'hA500_0004));
        wait_drain(40);
        check("fcnt_after_rst", 64'(frame_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
